// File: rtl/fft_sample_loader.sv
// Front-end loader for the radix-2 FFT: writes one N-point frame into working memory,
// kicks the AGU and holds off input until finish. Macro FFT_LOADER_BITREV_EN selects bit-reversed addressing.
module fft_sample_loader #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  input  logic            in_last,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [2*DW-1:0] wr_data,
  output logic            fft_start,
  input  logic            fft_finish,
  output logic            busy,
  output logic            frame_err,
  output logic [15:0]     frames_done
);

  typedef enum logic [1:0] {StLoad, StDrain, StKick, StWait} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     count_q, count_d;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [2*DW-1:0]   wr_data_q;
  logic              fft_start_q;
  logic              busy_q;
  logic              frame_err_q;
  logic [15:0]       frames_done_q;

  logic beat;
  logic last_slot;

  assign beat      = in_valid && in_ready_q;
  assign last_slot = (count_q == AW'(N - 1));

  function automatic logic [AW-1:0] addr_map(input logic [AW-1:0] c);
    logic [AW-1:0] r;
`ifdef FFT_LOADER_BITREV_EN
    for (int i = 0; i < int'(AW); i++) begin
      r[i] = c[int'(AW) - 1 - i];
    end
`else
    r = c;
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StLoad: begin
        if (beat) begin
          if (last_slot) begin
            count_d = '0;
            state_d = StDrain;
          end else if (in_last) begin
            // Early last: drop the partial frame and realign to a new one.
            count_d = '0;
          end else begin
            count_d = count_q + AW'(1);
          end
        end
      end
      StDrain: state_d = StKick;
      StKick:  state_d = StWait;
      StWait:  if (fft_finish) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StLoad;
      count_q       <= '0;
      in_ready_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      fft_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= (state_d == StLoad);
      busy_q      <= (state_d != StLoad);
      wr_en_q     <= beat;
      if (beat) begin
        wr_addr_q <= addr_map(count_q);
        wr_data_q <= {in_re, in_im};
      end
      fft_start_q <= (state_d == StKick);
      frame_err_q <= beat && (in_last != last_slot);
      if (state_d == StKick) begin
        frames_done_q <= frames_done_q + 16'd1;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign fft_start   = fft_start_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign frames_done = frames_done_q;

endmodule
